// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Holds the arbiter state encoding, the default abort data word and the timeout counter sizing helper.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int ctrWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals around the port arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;

    logic              stall_if;
    logic              stall_mem;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Watchdog counter for a busy memory transaction.
// expired flags the enabled cycle in which the count would reach TIMEOUT.
module mem_timeout_ctr
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = ctrWidth(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the load/store stage.
// Data requests win in IDLE; every transaction is watched by a timeout that sets a sticky bus error.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        stateNext;
    logic              memReqNext;
    logic              memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic [DATA_W-1:0] ifRdataNext;
    logic [DATA_W-1:0] dRdataNext;
    logic              ifValidNext;
    logic              dValidNext;
    logic              busErrNext;

    logic              busy;
    logic              timedOut;
    logic              ctrClear;
    logic              ctrEnable;
    logic              dGrant;
    logic              iGrant;
    logic [DATA_W-1:0] doneData;

    assign busy      = (state != IDLE);
    assign ctrEnable = busy && !bus.mem_ready;
    assign ctrClear  = !busy || bus.mem_ready || timedOut;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) timeoutCtr (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctrClear),
        .enable  (ctrEnable),
        .expired (timedOut)
    );

    // A requester still seeing its own valid pulse is finishing its handshake, not asking again.
    assign dGrant = bus.d_req && !bus.d_valid;
    assign iGrant = bus.if_req && !bus.if_valid;

    assign doneData = bus.mem_ready ? (bus.mem_we ? '0 : bus.mem_rdata) : ERR_DATA;

    assign bus.stall_if  = bus.if_req && !bus.if_valid;
    assign bus.stall_mem = bus.d_req && !bus.d_valid;

    always_comb begin
        stateNext    = state;
        memReqNext   = bus.mem_req;
        memWeNext    = bus.mem_we;
        memAddrNext  = bus.mem_addr;
        memWdataNext = bus.mem_wdata;
        ifRdataNext  = bus.if_rdata;
        dRdataNext   = bus.d_rdata;
        ifValidNext  = 1'b0;
        dValidNext   = 1'b0;
        busErrNext   = bus.bus_err;

        case (state)
            IDLE: begin
                if (dGrant) begin
                    stateNext    = BUSY_D;
                    memReqNext   = 1'b1;
                    memWeNext    = bus.d_we;
                    memAddrNext  = bus.d_addr;
                    memWdataNext = bus.d_wdata;
                end else if (iGrant) begin
                    stateNext   = BUSY_I;
                    memReqNext  = 1'b1;
                    memWeNext   = 1'b0;
                    memAddrNext = bus.if_addr;
                end
            end
            BUSY_I, BUSY_D: begin
                // A late mem_ready on the expiry cycle still counts as a normal completion.
                if (bus.mem_ready || timedOut) begin
                    if (state == BUSY_D) begin
                        dRdataNext = doneData;
                        dValidNext = 1'b1;
                    end else begin
                        ifRdataNext = doneData;
                        ifValidNext = 1'b1;
                    end
                    if (!bus.mem_ready) begin
                        busErrNext = 1'b1;
                    end
                    memReqNext = 1'b0;
                    stateNext  = IDLE;
                end
            end
            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.d_rdata   <= '0;
            bus.if_valid  <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.bus_err   <= 1'b0;
        end else begin
            state         <= stateNext;
            bus.mem_req   <= memReqNext;
            bus.mem_we    <= memWeNext;
            bus.mem_addr  <= memAddrNext;
            bus.mem_wdata <= memWdataNext;
            bus.if_rdata  <= ifRdataNext;
            bus.d_rdata   <= dRdataNext;
            bus.if_valid  <= ifValidNext;
            bus.d_valid   <= dValidNext;
            bus.bus_err   <= busErrNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed episode table, reset corner case, then random episodes.
// Expected behaviour comes from a transaction-level model of priority, latency and timeout rules.
module tb_mem_port_arbiter;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          TIMEOUT  = 4;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;
    localparam int          NUM_VECS = 8;
    localparam int          NUM_RAND = 40;

    typedef struct {
        bit          doI;
        bit          doD;
        bit          dWe;
        logic [31:0] ifAddr;
        logic [31:0] dAddr;
        logic [31:0] wdata;
        logic [31:0] rdI;
        logic [31:0] rdD;
        int          latI;
        int          latD;
        logic [31:0] expRdI;
        logic [31:0] expRdD;
        bit          expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    int          compCount = 0;
    int          failCount = 0;
    logic [31:0] lastWdata;
    bit          errModel;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

    mem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] refRdata(input bit isStore, input int lat, input logic [31:0] memWord);
        if (lat > TIMEOUT) return ERR_DATA;
        return isStore ? 32'h0 : memWord;
    endfunction

    // One episode: raise the requests together, then serve data before fetch, each with its own latency.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          nTx;
        bit          isD;
        int          lat;
        bit          aborted;
        logic [31:0] expRd;

        busIf.if_req    = v.doI;
        busIf.if_addr   = v.ifAddr;
        busIf.d_req     = v.doD;
        busIf.d_we      = v.dWe;
        busIf.d_addr    = v.dAddr;
        busIf.d_wdata   = v.wdata;
        busIf.mem_ready = 1'b0;
        nTx = int'(v.doI) + int'(v.doD);

        for (int t = 0; t < nTx; t++) begin
            isD = v.doD && (t == 0);
            tick();
            if (t > 0) busIf.d_req = 1'b0;
            if (isD) lastWdata = v.wdata;
            checkOutput({tag, " grant mem_req"}, busIf.mem_req, 1'b1);
            checkWord({tag, " grant mem_addr"}, busIf.mem_addr, isD ? v.dAddr : v.ifAddr);
            checkOutput({tag, " grant mem_we"}, busIf.mem_we, isD ? v.dWe : 1'b0);
            checkWord({tag, " grant mem_wdata"}, busIf.mem_wdata, lastWdata);

            lat = isD ? v.latD : v.latI;
            for (int k = 1; k <= TIMEOUT; k++) begin
                busIf.mem_ready = (k == lat);
                busIf.mem_rdata = (k == lat) ? (isD ? v.rdD : v.rdI) : $urandom();
                checkOutput({tag, " busy own stall"}, isD ? busIf.stall_mem : busIf.stall_if, 1'b1);
                if (isD && v.doI) checkOutput({tag, " busy stall_if"}, busIf.stall_if, 1'b1);
                tick();
                busIf.mem_ready = 1'b0;
                if (k == lat) break;
                if (k < TIMEOUT) begin
                    checkOutput({tag, " busy mem_req"}, busIf.mem_req, 1'b1);
                    checkOutput({tag, " busy early valid"}, isD ? busIf.d_valid : busIf.if_valid, 1'b0);
                end
            end

            aborted = (lat > TIMEOUT);
            if (aborted) errModel = 1'b1;
            expRd = isD ? v.expRdD : v.expRdI;
            checkOutput({tag, isD ? " d_valid pulse" : " if_valid pulse"},
                        isD ? busIf.d_valid : busIf.if_valid, 1'b1);
            checkOutput({tag, " other valid"}, isD ? busIf.if_valid : busIf.d_valid, 1'b0);
            checkWord({tag, isD ? " d_rdata" : " if_rdata"}, isD ? busIf.d_rdata : busIf.if_rdata, expRd);
            checkOutput({tag, " done mem_req"}, busIf.mem_req, 1'b0);
            checkOutput({tag, " done bus_err"}, busIf.bus_err, errModel);
            checkOutput({tag, " done own stall"}, isD ? busIf.stall_mem : busIf.stall_if, 1'b0);
            if (isD && v.doI) checkOutput({tag, " stall_if at d_valid"}, busIf.stall_if, 1'b1);
        end

        // Requests are still high across this edge; the turnaround guard must not reissue them.
        tick();
        checkOutput({tag, " guard mem_req"}, busIf.mem_req, 1'b0);
        checkOutput({tag, " guard if_valid"}, busIf.if_valid, 1'b0);
        checkOutput({tag, " guard d_valid"}, busIf.d_valid, 1'b0);
        busIf.if_req = 1'b0;
        busIf.d_req  = 1'b0;

        busIf.mem_ready = 1'($urandom_range(0, 1));
        tick();
        busIf.mem_ready = 1'b0;
        checkOutput({tag, " idle mem_req"}, busIf.mem_req, 1'b0);
        checkOutput({tag, " idle valid"}, busIf.if_valid | busIf.d_valid, 1'b0);
        checkOutput({tag, " episode bus_err"}, busIf.bus_err, v.expErr);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [NUM_VECS];
        vec_t r;
        int   sel;

        vecs[0] = '{1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0050_0093, 32'h0, 2, 0,
                    32'h0050_0093, 32'h0, 0};
        vecs[1] = '{1, 1, 1, 32'h0000_0014, 32'h0000_0100, 32'hCAFE_F00D, 32'h00A0_0113, 32'h5555_5555, 3, 1,
                    32'h00A0_0113, 32'h0, 0};
        vecs[2] = '{0, 1, 0, 32'h0, 32'h0000_0200, 32'h0, 32'h0, 32'h1234_5678, 0, 1,
                    32'h0, 32'h1234_5678, 0};
        vecs[3] = '{1, 0, 0, 32'h0000_0018, 32'h0, 32'h0, 32'h1111_1111, 32'h0, 4, 0,
                    32'h1111_1111, 32'h0, 0};
        vecs[4] = '{1, 0, 0, 32'h0000_001C, 32'h0, 32'h0, 32'h7777_7777, 32'h0, 9, 0,
                    32'h0000_0000, 32'h0, 1};
        vecs[5] = '{0, 1, 0, 32'h0, 32'h0000_0204, 32'hAAAA_0000, 32'h0, 32'hDEAD_BEEF, 0, 2,
                    32'h0, 32'hDEAD_BEEF, 1};
        vecs[6] = '{1, 1, 0, 32'h0000_0020, 32'h0000_0300, 32'h0101_0101, 32'h2222_2222, 32'h0BAD_F00D, 1, 3,
                    32'h2222_2222, 32'h0BAD_F00D, 1};
        vecs[7] = '{0, 1, 1, 32'h0, 32'h0000_0104, 32'h1357_9BDF, 32'h0, 32'h6666_6666, 0, 6,
                    32'h0, 32'h0000_0000, 1};

        rst             = 1'b0;
        busIf.if_req    = 1'b1;
        busIf.if_addr   = 32'h0000_0040;
        busIf.d_req     = 1'b0;
        busIf.d_we      = 1'b0;
        busIf.d_addr    = 32'h0;
        busIf.d_wdata   = 32'h0;
        busIf.mem_rdata = 32'h0;
        busIf.mem_ready = 1'b0;
        lastWdata       = 32'h0;
        errModel        = 1'b0;

        tick();
        tick();
        checkOutput("reset mem_req", busIf.mem_req, 1'b0);
        checkOutput("reset mem_we", busIf.mem_we, 1'b0);
        checkWord("reset mem_addr", busIf.mem_addr, 32'h0);
        checkWord("reset mem_wdata", busIf.mem_wdata, 32'h0);
        checkWord("reset if_rdata", busIf.if_rdata, 32'h0);
        checkWord("reset d_rdata", busIf.d_rdata, 32'h0);
        checkOutput("reset if_valid", busIf.if_valid, 1'b0);
        checkOutput("reset d_valid", busIf.d_valid, 1'b0);
        checkOutput("reset bus_err", busIf.bus_err, 1'b0);
        busIf.if_req = 1'b0;
        rst          = 1'b1;
        tick();
        checkOutput("post-reset idle mem_req", busIf.mem_req, 1'b0);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a load: the request must drop and the sticky error must clear.
        busIf.d_req  = 1'b1;
        busIf.d_we   = 1'b0;
        busIf.d_addr = 32'h0000_0400;
        tick();
        checkOutput("rstmid grant mem_req", busIf.mem_req, 1'b1);
        tick();
        checkOutput("rstmid busy mem_req", busIf.mem_req, 1'b1);
        rst = 1'b0;
        tick();
        busIf.d_req = 1'b0;
        checkOutput("rstmid mem_req", busIf.mem_req, 1'b0);
        checkOutput("rstmid d_valid", busIf.d_valid, 1'b0);
        checkOutput("rstmid bus_err", busIf.bus_err, 1'b0);
        errModel  = 1'b0;
        lastWdata = 32'h0;
        rst = 1'b1;
        tick();
        checkOutput("rstmid after mem_req", busIf.mem_req, 1'b0);
        checkOutput("rstmid after d_valid", busIf.d_valid, 1'b0);
        r = '{0, 1, 0, 32'h0, 32'h0000_0408, 32'h0F0F_0F0F, 32'h0, 32'h8765_4321, 0, 2,
              32'h0, 32'h8765_4321, 0};
        applyStimulus(r, "rstmid-new");

        for (int e = 0; e < NUM_RAND; e++) begin
            sel      = $urandom_range(0, 2);
            r.doI    = (sel != 1);
            r.doD    = (sel != 0);
            r.dWe    = 1'($urandom_range(0, 1));
            r.ifAddr = $urandom() & 32'hFFFF_FFFC;
            r.dAddr  = $urandom() & 32'hFFFF_FFFC;
            r.wdata  = $urandom();
            r.rdI    = $urandom();
            r.rdD    = $urandom();
            r.latI   = $urandom_range(1, TIMEOUT + 2);
            r.latD   = $urandom_range(1, TIMEOUT + 2);
            r.expRdI = refRdata(1'b0, r.latI, r.rdI);
            r.expRdD = refRdata(r.dWe, r.latD, r.rdD);
            r.expErr = errModel || (r.doI && r.latI > TIMEOUT) || (r.doD && r.latD > TIMEOUT);
            applyStimulus(r, $sformatf("rand%0d", e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
